// File: rtl/avalon_pio_irq.sv
// Avalon-MM PIO slave: set/clear output register, synchronised inputs with edge capture and maskable irq.
// Optional input debounce filter is enabled by defining PIO_DEBOUNCE_EN.
module avalon_pio_irq #(
  parameter int               WIDTH        = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               EDGE_TYPE    = 0,
  parameter int               SYNC_STAGES  = 2,
  parameter int               DEBOUNCE_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA_OUT = 3'd0;
  localparam logic [2:0] A_DATA_IN  = 3'd1;
  localparam logic [2:0] A_IRQ_MASK = 3'd2;
  localparam logic [2:0] A_EDGE_CAP = 3'd3;
  localparam logic [2:0] A_OUT_SET  = 3'd4;
  localparam logic [2:0] A_OUT_CLR  = 3'd5;
  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("avalon_pio_irq: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("avalon_pio_irq: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_DIV < 2) begin : g_bad_div
    $error("avalon_pio_irq: DEBOUNCE_DIV must be >= 2");
  end

  function automatic logic [WIDTH-1:0] edge_detect(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prv);
    case (EDGE_TYPE)
      32'sd0:  return cur & ~prv;
      32'sd1:  return ~cur & prv;
      default: return cur ^ prv;
    endcase
  endfunction

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] in_f;
  logic             ticks_ok;
  logic [2:0]       prime_cnt;
  logic             armed;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_word;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign in_s      = sync_q[SYNC_STAGES-1];

  // Input synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam logic [31:0] TICK_LAST = 32'(DEBOUNCE_DIV - 1);

  logic [31:0]      tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] smp;
  logic [WIDTH-1:0] in_f_q;
  logic [WIDTH-1:0] agree;
  logic [1:0]       tick_seen;

  assign tick     = (tick_cnt == TICK_LAST);
  assign agree    = ~(in_s ^ smp);
  assign in_f     = in_f_q;
  // tick_seen reaches 3 one cycle after the second tick so prev has caught up with in_f
  assign ticks_ok = (tick_seen == 2'd3);

  // Debounce: a bit follows the input only after two consecutive tick samples agree
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= 32'd0;
      smp       <= '0;
      in_f_q    <= '0;
      tick_seen <= 2'd0;
    end else begin
      tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
      if (tick) begin
        smp    <= in_s;
        in_f_q <= (agree & in_s) | (~agree & in_f_q);
      end
      if (tick_seen == 2'd2) begin
        tick_seen <= 2'd3;
      end else if (tick && tick_seen != 2'd3) begin
        tick_seen <= tick_seen + 2'd1;
      end
    end
  end
`else
  assign in_f     = in_s;
  assign ticks_ok = 1'b1;
`endif

  assign armed = (prime_cnt == PRIME_LAST) && ticks_ok;

  // Priming counter keeps edge capture off until the synchroniser holds real input data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= 3'd0;
    end else if (prime_cnt != PRIME_LAST) begin
      prime_cnt <= prime_cnt + 3'd1;
    end
  end

  // Edge-detect and write-1-to-clear terms; a new edge beats a clear on the same bit
  always_comb begin
    det = armed ? edge_detect(in_f, prev) : '0;
    if (wr && address == A_EDGE_CAP) begin
      clr = wd;
    end else begin
      clr = '0;
    end
  end

  // Register file updates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= RESET_VALUE;
      mask     <= '0;
      edge_cap <= '0;
      prev     <= '0;
    end else begin
      prev     <= in_f;
      edge_cap <= (edge_cap & ~clr) | det;
      if (wr) begin
        case (address)
          A_DATA_OUT: out_reg <= wd;
          A_OUT_SET:  out_reg <= out_reg | wd;
          A_OUT_CLR:  out_reg <= out_reg & ~wd;
          A_IRQ_MASK: mask    <= wd;
          default:    ;
        endcase
      end
    end
  end

  // Zero-latency read mux; unmapped and write-only addresses read 0
  always_comb begin
    rd_word = 32'd0;
    case (address)
      A_DATA_OUT: rd_word[WIDTH-1:0] = out_reg;
      A_DATA_IN:  rd_word[WIDTH-1:0] = in_f;
      A_IRQ_MASK: rd_word[WIDTH-1:0] = mask;
      A_EDGE_CAP: rd_word[WIDTH-1:0] = edge_cap;
      default:    rd_word = 32'd0;
    endcase
  end

  assign readdata = rd_word;
  assign out_port = out_reg;
  assign irq      = |(edge_cap & mask);

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Scoreboard bench for avalon_pio_irq: expectations are queued at stimulus time and popped at observation.
module tb_avalon_pio_irq;
  localparam int WIDTH = 18;

  logic              clk;
  logic              reset_n;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [WIDTH-1:0]  in_port;
  logic [WIDTH-1:0]  out_port;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  avalon_pio_irq #(
    .WIDTH(WIDTH), .RESET_VALUE(18'h2A5A5), .EDGE_TYPE(0),
    .SYNC_STAGES(2), .DEBOUNCE_DIV(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] rd;

  initial begin
    reset_n    = 1'b0;
    address    = 3'd3;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 18'h00001;

    // reset state
    push_exp("rst_out_port", 32'h0002_A5A5);
    push_exp("rst_irq", 32'd0);
    push_exp("rst_edge_cap", 32'd0);
    push_exp("rst_rd_data_out", 32'h0002_A5A5);
    step(3);
    observe(32'(out_port));
    observe(32'(irq));
    bus_read(3'd3, rd); observe(rd);
    bus_read(3'd0, rd); observe(rd);
    reset_n = 1'b1;

    // output register: load, clear, set
    bus_write(3'd0, 32'hFFFF_FFFF);
    push_exp("out_load", 32'h0003_FFFF);
    observe(32'(out_port));
    bus_write(3'd5, 32'h0000_000F);
    bus_write(3'd4, 32'h0002_0000);
    push_exp("out_setclr_port", 32'h0003_FFF0);
    push_exp("out_rd_addr0", 32'h0003_FFF0);
    push_exp("rd_addr4_zero", 32'd0);
    push_exp("rd_addr5_zero", 32'd0);
    observe(32'(out_port));
    bus_read(3'd0, rd); observe(rd);
    bus_read(3'd4, rd); observe(rd);
    bus_read(3'd5, rd); observe(rd);
    bus_write(3'd6, 32'h0000_0000);
    push_exp("unmapped_write_ignored", 32'h0003_FFF0);
    push_exp("rd_addr6_zero", 32'd0);
    observe(32'(out_port));
    bus_read(3'd6, rd); observe(rd);
    address = 3'd0; writedata = 32'd0; write_n = 1'b0; chipselect = 1'b0;
    push_exp("cs_low_write_ignored", 32'h0003_FFF0);
    step(1);
    write_n = 1'b1;
    observe(32'(out_port));
    bus_write(3'd4, 32'h0000_0003);
    push_exp("out_set_low_bits", 32'h0003_FFF3);
    observe(32'(out_port));

`ifndef PIO_DEBOUNCE_EN
    // input held high through reset must not be captured
    push_exp("prime_edge_cap", 32'd0);
    push_exp("prime_data_in", 32'h0000_0001);
    step(2);
    bus_read(3'd3, rd); observe(rd);
    bus_read(3'd1, rd); observe(rd);

    // rising edge latency: not yet after 2 edges, captured on the 3rd
    in_port = 18'h00003;
    push_exp("lat_2_edges", 32'd0);
    push_exp("lat_3_edges", 32'h0000_0002);
    step(2);
    bus_read(3'd3, rd); observe(rd);
    step(1);
    bus_read(3'd3, rd); observe(rd);

    // mask raises irq; W1C drops it
    bus_write(3'd2, 32'h0000_0002);
    push_exp("mask_irq_set", 32'd1);
    push_exp("mask_readback", 32'h0000_0002);
    observe(32'(irq));
    bus_read(3'd2, rd); observe(rd);
    bus_write(3'd3, 32'h0000_0002);
    push_exp("w1c_edge_cap", 32'd0);
    push_exp("w1c_irq", 32'd0);
    bus_read(3'd3, rd); observe(rd);
    observe(32'(irq));

    // falling edge ignored in rising mode
    in_port = 18'h00001;
    push_exp("falling_ignored", 32'd0);
    step(4);
    bus_read(3'd3, rd); observe(rd);

    // recapture bit1
    in_port = 18'h00003;
    push_exp("recapture_edge_cap", 32'h0000_0002);
    push_exp("recapture_irq", 32'd1);
    step(3);
    bus_read(3'd3, rd); observe(rd);
    observe(32'(irq));

    // W1C on the same edge that a new rising edge is captured: edge wins
    in_port = 18'h00001;
    step(4);
    in_port = 18'h00003;
    step(2);
    bus_write(3'd3, 32'h0000_0002);
    push_exp("edge_beats_w1c", 32'h0000_0002);
    push_exp("edge_beats_w1c_irq", 32'd1);
    bus_read(3'd3, rd); observe(rd);
    observe(32'(irq));
    bus_write(3'd3, 32'h0000_0002);
    push_exp("w1c_no_edge", 32'd0);
    push_exp("w1c_no_edge_irq", 32'd0);
    bus_read(3'd3, rd); observe(rd);
    observe(32'(irq));
`else
    // debounced input held through reset: data appears, no capture
    push_exp("db_prime_data_in", 32'h0000_0001);
    push_exp("db_prime_edge_cap", 32'd0);
    step(20);
    bus_read(3'd1, rd); observe(rd);
    bus_read(3'd3, rd); observe(rd);
    in_port = 18'h00000;
    push_exp("db_low_data_in", 32'd0);
    step(16);
    bus_read(3'd1, rd); observe(rd);

    // 3-cycle glitch is rejected
    in_port = 18'h00001;
    step(3);
    in_port = 18'h00000;
    push_exp("db_glitch_data_in", 32'd0);
    push_exp("db_glitch_edge_cap", 32'd0);
    step(12);
    bus_read(3'd1, rd); observe(rd);
    bus_read(3'd3, rd); observe(rd);

    // held level passes and is captured
    in_port = 18'h00001;
    push_exp("db_level_data_in", 32'h0000_0001);
    push_exp("db_level_edge_cap", 32'h0000_0001);
    step(12);
    bus_read(3'd1, rd); observe(rd);
    step(2);
    bus_read(3'd3, rd); observe(rd);

    bus_write(3'd2, 32'h0000_0001);
    push_exp("db_mask_irq", 32'd1);
    observe(32'(irq));
    bus_write(3'd3, 32'h0000_0001);
    push_exp("db_w1c_irq", 32'd0);
    observe(32'(irq));
`endif

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
